// File: rtl/arith_cmd_sequencer_29_pkg.sv
// Shared definitions for the arithmetic command sequencer: opcodes, legality check, FSM states.
package arith_pkg_29;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_SHIFT = 4'b0000;
  localparam logic [OP_W-1:0] OP_CMP   = 4'b0001;
  localparam logic [OP_W-1:0] OP_DIV   = 4'b0010;
  localparam logic [OP_W-1:0] OP_ZM2U2 = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_SHIFT) || (op == OP_CMP) || (op == OP_DIV) || (op == OP_ZM2U2);
  endfunction

endpackage

// File: rtl/arith_cmd_sequencer_29_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, exact occupancy count.
module arith_cmd_fifo #(
  parameter int unsigned W     = 68,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata_c,
  output logic          o_full_c,
  output logic          o_empty_c,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata_c = r_mem[r_rptr];

  // A full FIFO refuses a push even if the head is popped in the same cycle
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/arith_cmd_sequencer_29.sv
// Command front-end for the arithmetic unit: queues commands, issues one at a time,
// waits a fixed latency, and returns the captured result on a valid/ready port.
module arith_cmd_sequencer_29
  import arith_pkg_29::*;
#(
  parameter int unsigned M     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [M-1:0]           i_cmd_A,
  input  logic [M-1:0]           i_cmd_B,
  input  logic [3:0]             i_cmd_op,
  output logic [M-1:0]           o_arg_A,
  output logic [M-1:0]           o_arg_B,
  output logic [3:0]             o_op,
  input  logic [M-1:0]           i_unit_result,
  input  logic [3:0]             i_unit_status,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [M-1:0]           o_rsp_result,
  output logic [3:0]             o_rsp_status,
  output logic [3:0]             o_rsp_op,
  output logic                   o_rsp_err,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned FW = 2 * M + OP_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned LW = $clog2(LAT + 1);

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic [LW-1:0] r_wait;
  logic [LW-1:0] w_wait_nxt;

  logic [M-1:0]    r_arg_A;
  logic [M-1:0]    r_arg_B;
  logic [OP_W-1:0] r_op;
  logic            r_rsp_valid;
  logic [M-1:0]    r_rsp_result;
  logic [3:0]      r_rsp_status;
  logic [OP_W-1:0] r_rsp_op;
  logic            r_rsp_err;

  logic            w_pop;
  logic            w_issue;
  logic            w_reject;
  logic            w_capture;
  logic            w_full;
  logic            w_empty;
  logic [FW-1:0]   w_head;
  logic [M-1:0]    w_head_A;
  logic [M-1:0]    w_head_B;
  logic [OP_W-1:0] w_head_op;
  logic [CW-1:0]   w_count;

  arith_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_push    (i_cmd_valid),
    .i_wdata   ({i_cmd_A, i_cmd_B, i_cmd_op}),
    .i_pop     (w_pop),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  assign w_head_A  = w_head[FW-1 -: M];
  assign w_head_B  = w_head[OP_W +: M];
  assign w_head_op = w_head[OP_W-1:0];

  assign o_cmd_ready  = !w_full;
  assign o_count      = w_count;
  assign o_arg_A      = r_arg_A;
  assign o_arg_B      = r_arg_B;
  assign o_op         = r_op;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_status = r_rsp_status;
  assign o_rsp_op     = r_rsp_op;
  assign o_rsp_err    = r_rsp_err;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Capture fires on the edge where the wait counter steps from 1 to 0,
  // i.e. exactly LAT edges after the operands were registered.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_reject    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (is_legal_op(w_head_op)) begin
            w_issue     = 1'b1;
            w_wait_nxt  = LW'(LAT);
            w_state_nxt = WAIT;
          end else begin
            w_reject    = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      WAIT: begin
        w_wait_nxt = r_wait - LW'(1);
        if (r_wait == LW'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (i_rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand and response registers; operands keep their last issued values when idle
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_arg_A      <= '0;
      r_arg_B      <= '0;
      r_op         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_status <= '0;
      r_rsp_op     <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_arg_A <= w_head_A;
        r_arg_B <= w_head_B;
        r_op    <= w_head_op;
      end
      if (w_capture) begin
        r_rsp_result <= i_unit_result;
        r_rsp_status <= i_unit_status;
        r_rsp_op     <= r_op;
        r_rsp_err    <= 1'b0;
      end
      if (w_reject) begin
        r_rsp_result <= '0;
        r_rsp_status <= '0;
        r_rsp_op     <= w_head_op;
        r_rsp_err    <= 1'b1;
      end
      r_rsp_valid <= (w_state_nxt == HOLD);
    end
  end

endmodule

// File: tb/tb_arith_cmd_sequencer_29.sv
// Bench: two sequencers (LAT=1 and LAT=3) fed the same command stream, each driving a
// behavioural unit that is only correct at the exact latency; responses are scoreboarded.
module tb_arith_cmd_sequencer_29;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  status;
    logic [3:0]  op;
    logic        err;
    logic [31:0] arg_a;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] c_A, c_B;
  logic [3:0]  c_op;
  logic        rsp_rdy;
  logic        cv1, cv3, cr1, cr3;
  logic [31:0] aA1, aB1, aA3, aB3, ur1, ur3, rr1, rr3;
  logic [3:0]  aop1, aop3, us1, us3, rs1, rs3, ro1, ro3;
  logic        rv1, rv3, re1, re3;
  logic [2:0]  cnt1, cnt3;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rnd_rdy = 0;
  logic [31:0] cyc = '0;
  logic [31:0] last_legal_A;
  rsp_t exp_q[$];
  rsp_t got1[$];
  rsp_t got3[$];

  always #5 clk = ~clk;

  arith_cmd_sequencer_29 #(.M(32), .DEPTH(4), .LAT(1)) u_dut1 (
    .clk(clk), .i_reset(rst), .i_cmd_valid(cv1), .o_cmd_ready(cr1),
    .i_cmd_A(c_A), .i_cmd_B(c_B), .i_cmd_op(c_op),
    .o_arg_A(aA1), .o_arg_B(aB1), .o_op(aop1),
    .i_unit_result(ur1), .i_unit_status(us1),
    .o_rsp_valid(rv1), .i_rsp_ready(rsp_rdy), .o_rsp_result(rr1),
    .o_rsp_status(rs1), .o_rsp_op(ro1), .o_rsp_err(re1), .o_count(cnt1)
  );

  arith_cmd_sequencer_29 #(.M(32), .DEPTH(4), .LAT(3)) u_dut3 (
    .clk(clk), .i_reset(rst), .i_cmd_valid(cv3), .o_cmd_ready(cr3),
    .i_cmd_A(c_A), .i_cmd_B(c_B), .i_cmd_op(c_op),
    .o_arg_A(aA3), .o_arg_B(aB3), .o_op(aop3),
    .i_unit_result(ur3), .i_unit_status(us3),
    .o_rsp_valid(rv3), .i_rsp_ready(rsp_rdy), .o_rsp_result(rr3),
    .o_rsp_status(rs3), .o_rsp_op(ro3), .o_rsp_err(re3), .o_count(cnt3)
  );

  // Stand-in arithmetic: {status, result}
  function automatic logic [35:0] unit_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:    r = a << b[4:0];
      4'd1:    r = {30'd0, a == b, a < b};
      4'd2:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd3:    r = a[31] ? (~{1'b0, a[30:0]} + 32'd1) : a;
      default: r = '0;
    endcase
    return {r == 0, a[0], op[1:0], r};
  endfunction

  // Output is the true result only when the operands have been stable for exactly lat-1 cycles
  function automatic logic [35:0] unit_model(input int unsigned lat, input int unsigned age,
                                             input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] cy);
    if (age == lat - 1) return unit_ref(op, a, b);
    return {cy[3:0] ^ 4'h5, 32'hDEAD_0000 ^ cy};
  endfunction

  logic [67:0] last1 = '0, last3 = '0;
  int unsigned age1 = 0, age3 = 0;
  logic chg1, chg3;
  assign chg1 = ({aA1, aB1, aop1} != last1);
  assign chg3 = ({aA3, aB3, aop3} != last3);

  always @(posedge clk) begin
    cyc   <= cyc + 32'd1;
    last1 <= {aA1, aB1, aop1};
    last3 <= {aA3, aB3, aop3};
    age1  <= chg1 ? 1 : age1 + 1;
    age3  <= chg3 ? 1 : age3 + 1;
  end

  always_comb begin
    {us1, ur1} = unit_model(1, chg1 ? 0 : age1, aop1, aA1, aB1, cyc);
    {us3, ur3} = unit_model(3, chg3 ? 0 : age3, aop3, aA3, aB3, cyc);
  end

  // Record each response handshake that will complete on the coming rising edge
  always @(negedge clk) begin
    if (!rst && rsp_rdy && rv1) got1.push_back('{rr1, rs1, ro1, re1, aA1});
    if (!rst && rsp_rdy && rv3) got3.push_back('{rr3, rs3, ro3, re3, aA3});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cmp_rec(input string tag, input rsp_t g, input rsp_t e);
    chk({tag, " result"}, g.result, e.result);
    chk({tag, " status"}, 32'(g.status), 32'(e.status));
    chk({tag, " op"}, 32'(g.op), 32'(e.op));
    chk({tag, " err"}, 32'(g.err), 32'(e.err));
    chk({tag, " held_arg_A"}, g.arg_a, e.arg_a);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit d1 = 0, d3 = 0;
    int t = 0;
    logic [35:0] sr;
    c_A = a; c_B = b; c_op = op; cv1 = 1'b1; cv3 = 1'b1;
    while (!(d1 && d3) && t < 100) begin
      if (rnd_rdy) rsp_rdy = 1'($urandom_range(0, 1));
      if (cv1 && cr1) d1 = 1;
      if (cv3 && cr3) d3 = 1;
      @(posedge clk); #1;
      if (d1) cv1 = 1'b0;
      if (d3) cv3 = 1'b0;
      t++;
    end
    cv1 = 1'b0; cv3 = 1'b0;
    chk("push accepted", {30'd0, d1, d3}, 32'h3);
    if (op < 4) begin
      sr = unit_ref(op, a, b);
      exp_q.push_back('{sr[31:0], sr[35:32], op, 1'b0, a});
      last_legal_A = a;
    end else begin
      exp_q.push_back('{32'd0, 4'd0, op, 1'b1, last_legal_A});
    end
  endtask

  task automatic drain_check(input string tag);
    int n = exp_q.size();
    int w = 0;
    rsp_rdy = 1'b1;
    while ((got1.size() < n || got3.size() < n) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk({tag, " count lat1"}, 32'(got1.size()), 32'(n));
    chk({tag, " count lat3"}, 32'(got3.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < got1.size()) cmp_rec($sformatf("%s lat1 #%0d", tag, k), got1[k], exp_q[k]);
      if (k < got3.size()) cmp_rec($sformatf("%s lat3 #%0d", tag, k), got3[k], exp_q[k]);
    end
    exp_q.delete(); got1.delete(); got3.delete();
  endtask

  initial begin
    rst = 1'b1; cv1 = 1'b0; cv3 = 1'b0; rsp_rdy = 1'b0;
    c_A = '0; c_B = '0; c_op = '0; last_legal_A = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst rsp_valid1", 32'(rv1), 0);   chk("rst rsp_valid3", 32'(rv3), 0);
    chk("rst count1", 32'(cnt1), 0);      chk("rst count3", 32'(cnt3), 0);
    chk("rst cmd_ready1", 32'(cr1), 1);   chk("rst cmd_ready3", 32'(cr3), 1);
    chk("rst op1", 32'(aop1), 0);         chk("rst arg_A3", aA3, 0);
    chk("rst rsp_result1", rr1, 0);       chk("rst rsp_err3", 32'(re3), 0);

    // Reset while a command is waiting on the unit
    push(32'h55, 32'h3, 4'd2);
    @(posedge clk); #1;
    chk("midwait op1", 32'(aop1), 2);
    chk("midwait op3", 32'(aop3), 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset2 rsp_valid1", 32'(rv1), 0); chk("reset2 rsp_valid3", 32'(rv3), 0);
    chk("reset2 count1", 32'(cnt1), 0);    chk("reset2 count3", 32'(cnt3), 0);
    chk("reset2 op1", 32'(aop1), 0);       chk("reset2 op3", 32'(aop3), 0);
    chk("reset2 ready1", 32'(cr1), 1);     chk("reset2 ready3", 32'(cr3), 1);
    exp_q.delete(); last_legal_A = '0;
    rsp_rdy = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("dropped cmd lat1", 32'(got1.size()), 0);
    chk("dropped cmd lat3", 32'(got3.size()), 0);

    // Divide, then sign-magnitude conversions
    push(32'd100, 32'd10, 4'b0010);
    drain_check("div");
    push(32'h8000_0001, 32'd0, 4'b0011);
    push(32'h7FFF_FFFF, 32'd0, 4'b0011);
    drain_check("zm2u2");

    // Illegal opcode between two legal commands
    push(32'h1111_0000, 32'd4, 4'b0000);
    push(32'h0000_AAAA, 32'h0000_BBBB, 4'b0101);
    push(32'h50, 32'h50, 4'b0001);
    drain_check("illegal");

    // Backpressure: one in flight plus a full FIFO, sixth command refused
    rsp_rdy = 1'b0;
    for (int k = 0; k < 5; k++) push(32'h1000 + 32'(k), 32'(k + 1), 4'(k % 4));
    chk("full count1", 32'(cnt1), 4);  chk("full count3", 32'(cnt3), 4);
    chk("full ready1", 32'(cr1), 0);   chk("full ready3", 32'(cr3), 0);
    c_A = 32'h9999; c_B = 32'h7; c_op = 4'd2; cv1 = 1'b1; cv3 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cv1 = 1'b0; cv3 = 1'b0;
    chk("sixth refused count1", 32'(cnt1), 4);
    chk("sixth refused count3", 32'(cnt3), 4);
    drain_check("backpressure");

    // Random commands (some illegal) with random response backpressure
    rnd_rdy = 1;
    for (int k = 0; k < 24; k++) push($urandom, $urandom, 4'($urandom_range(0, 7)));
    rnd_rdy = 0;
    drain_check("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
